fifo_flagged: RTL

Parametrised synchronous FIFO with arbitrary (non-power-of-two) depth, occupancy count, programmable almost-empty/almost-full flags, sticky overflow/underflow error flags and a selectable read mode (registered read or first-word-fall-through). It is the general-purpose buffering block between producer/consumer stages in the datapath and supersedes the fixed-flag FIFO for all new instances. It is single clock domain, with no CDC.

---
 rtl/fifo_flagged_if.sv | 55 +++++
 rtl/fifo_flagged.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fifo_flagged_if.sv
// fifo_flagged_if: producer/consumer handshake bundle for fifo_flagged.
// The master side drives push/pop/clear requests and observes data and flags;
// the slave side is the FIFO itself.
interface fifo_flagged_if #(
    parameter int data_w = 8,
    parameter int depth  = 4
);
    localparam int cnt_w = $clog2(depth + 1);

    logic              push_i;
    logic [data_w-1:0] push_data_i;
    logic              pop_i;
    logic              clr_err_i;
    logic [data_w-1:0] pop_data_o;
    logic              pop_valid_o;
    logic [cnt_w-1:0]  count_o;
    logic              e_o;
    logic              f_o;
    logic              ae_o;
    logic              af_o;
    logic              ovf_o;
    logic              udf_o;

    modport master (
        output push_i,
        output push_data_i,
        output pop_i,
        output clr_err_i,
        input  pop_data_o,
        input  pop_valid_o,
        input  count_o,
        input  e_o,
        input  f_o,
        input  ae_o,
        input  af_o,
        input  ovf_o,
        input  udf_o
    );

    modport slave (
        input  push_i,
        input  push_data_i,
        input  pop_i,
        input  clr_err_i,
        output pop_data_o,
        output pop_valid_o,
        output count_o,
        output e_o,
        output f_o,
        output ae_o,
        output af_o,
        output ovf_o,
        output udf_o
    );
endinterface

// File: rtl/fifo_flagged.sv
// fifo_flagged: single-clock FIFO of arbitrary depth with an occupancy
// counter, programmable almost-empty/almost-full thresholds, sticky
// overflow/underflow flags and either a registered or a first-word-fall-through
// read port.
module fifo_flagged #(
    parameter int data_w = 8,
    parameter int depth  = 4,
    parameter int ae_lvl = 1,
    parameter int af_lvl = depth - 1,
    parameter int fwft   = 0
) (
    input  logic          clock,
    input  logic          reset,
    fifo_flagged_if.slave bus
);
    // Pointer index width; the extra wrap bit distinguishes full from empty
    // when the indices coincide, which works for any depth because the index
    // is wrapped explicitly at depth-1 rather than by binary overflow.
    localparam int ptr_w = ($clog2(depth) > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth + 1);

    localparam logic [ptr_w-1:0] last_ptr  = ptr_w'(depth - 1);
    localparam logic [cnt_w-1:0] depth_cnt = cnt_w'(depth);
    localparam logic [cnt_w-1:0] ae_cnt    = cnt_w'(ae_lvl);
    localparam logic [cnt_w-1:0] af_cnt    = cnt_w'(af_lvl);

    logic [data_w-1:0] mem [depth];

    logic [ptr_w-1:0]  wr_ptr;
    logic [ptr_w-1:0]  rd_ptr;
    logic              wr_wrap;
    logic              rd_wrap;
    logic [cnt_w-1:0]  count;
    logic              ovf;
    logic              udf;

    logic              empty;
    logic              full;
    logic              push_ok;
    logic              pop_ok;

    // Advance a {wrap, index} pointer: the index returns to 0 after depth-1
    // and the wrap bit toggles at that moment.
    function automatic logic [ptr_w:0] ptr_adv(input logic [ptr_w:0] cur);
        logic [ptr_w:0] nxt;
        if (cur[ptr_w-1:0] == last_ptr) begin
            nxt = {~cur[ptr_w], {ptr_w{1'b0}}};
        end else begin
            nxt = {cur[ptr_w], cur[ptr_w-1:0] + ptr_w'(1)};
        end
        return nxt;
    endfunction

    // Occupancy step: +1 on a lone push, -1 on a lone pop, hold otherwise.
    function automatic logic [cnt_w-1:0] cnt_step(input logic [cnt_w-1:0] cur,
                                                  input logic push_acc,
                                                  input logic pop_acc);
        logic [cnt_w-1:0] nxt;
        nxt = cur;
        if (push_acc && !pop_acc) begin
            nxt = cur + cnt_w'(1);
        end else if (pop_acc && !push_acc) begin
            nxt = cur - cnt_w'(1);
        end
        return nxt;
    endfunction

    // Full/empty come from the pointers; both gate acceptance using the
    // flag values held at the start of the cycle.
    assign empty   = (rd_ptr == wr_ptr) && (rd_wrap == wr_wrap);
    assign full    = (rd_ptr == wr_ptr) && (rd_wrap != wr_wrap);
    assign push_ok = bus.push_i && !full;
    assign pop_ok  = bus.pop_i && !empty;

    // Pointer and occupancy state: moves only on accepted operations.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr  <= '0;
            wr_wrap <= 1'b0;
            rd_ptr  <= '0;
            rd_wrap <= 1'b0;
            count   <= '0;
        end else begin
            if (push_ok) begin
                {wr_wrap, wr_ptr} <= ptr_adv({wr_wrap, wr_ptr});
            end
            if (pop_ok) begin
                {rd_wrap, rd_ptr} <= ptr_adv({rd_wrap, rd_ptr});
            end
            count <= cnt_step(count, push_ok, pop_ok);
        end
    end

    // Storage array: written on accepted pushes only, never reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= bus.push_data_i;
        end
    end

    // Sticky error flags: a new error in the same cycle as a clear wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (bus.push_i && full) begin
                ovf <= 1'b1;
            end else if (bus.clr_err_i) begin
                ovf <= 1'b0;
            end
            if (bus.pop_i && empty) begin
                udf <= 1'b1;
            end else if (bus.clr_err_i) begin
                udf <= 1'b0;
            end
        end
    end

    generate
        if (fwft != 0) begin : g_fwft
            // Head word presented combinationally; forced to zero while empty
            // so the port reads 0 out of reset and never shows a stale word.
            assign bus.pop_valid_o = !empty;
            assign bus.pop_data_o  = empty ? '0 : mem[rd_ptr];
        end else begin : g_reg
            logic [data_w-1:0] rd_data_p1;
            logic              vld_p1;

            // ---- stage p1: registered read, valid pulses once per pop ----
            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    rd_data_p1 <= '0;
                    vld_p1     <= 1'b0;
                end else begin
                    vld_p1 <= pop_ok;
                    if (pop_ok) begin
                        rd_data_p1 <= mem[rd_ptr];
                    end
                end
            end

            assign bus.pop_valid_o = vld_p1;
            assign bus.pop_data_o  = rd_data_p1;
        end
    endgenerate

    // Status outputs all decode from registers, with no input-to-output path.
    assign bus.count_o = count;
    assign bus.e_o     = empty;
    assign bus.f_o     = full;
    assign bus.ae_o    = (count <= ae_cnt);
    assign bus.af_o    = (count >= af_cnt);
    assign bus.ovf_o   = ovf;
    assign bus.udf_o   = udf;

    // depth_cnt documents the upper bound of count; kept for readability of
    // the range the counter spans.
    logic unused_depth_cnt;
    assign unused_depth_cnt = ^depth_cnt;

endmodule
